// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by decode, EX and the MEM-stage load/store unit.
//   - mem_op bit positions: [4]=store, [3]=load, [2:0]=funct3
//   - funct3 size/sign encodings for loads and stores
//   - major opcodes for load and store instructions
//   - MEM-stage FSM state type
package cpu_pkg;

  localparam int unsigned MEMOP_STORE = 4;
  localparam int unsigned MEMOP_LOAD  = 3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane helper for the MEM stage.
//   mem_op_i   : current mem_op (store/load flags + funct3)
//   addr_lo_i  : low two bits of the effective address
//   st_data_i  : raw store data
//   ld_f3_i    : funct3 of the outstanding load
//   ld_off_i   : byte offset of the outstanding load
//   rdata_i    : raw read data from the bus
//   is_mem_o   : mem_op requests a load or store
//   fault_o    : access is misaligned or illegal
//   wstrb_o    : store byte enables (0 for loads)
//   wdata_o    : lane-replicated store data
//   ld_data_o  : extracted and extended load value
module mem_align
  import cpu_pkg::*;
(
  input  logic [4:0]  mem_op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] st_data_i,
  input  logic [2:0]  ld_f3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic        is_mem_o,
  output logic        fault_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_data_o
);

  logic        is_st;
  logic        is_ld;
  logic [2:0]  f3;
  logic        illegal;
  logic        misal;
  logic [31:0] rshift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    is_st    = mem_op_i[MEMOP_STORE];
    is_ld    = mem_op_i[MEMOP_LOAD];
    f3       = mem_op_i[2:0];
    is_mem_o = is_st | is_ld;

    illegal = (is_st && is_ld)
            || (is_ld && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111))
            || (is_st && (f3 >= 3'b011));
    // f3[1:0] picks the access size for both signed and unsigned loads.
    misal   = is_mem_o && (((f3[1:0] == 2'b01) && addr_lo_i[0])
                        || ((f3[1:0] == 2'b10) && (addr_lo_i != 2'b00)));
    fault_o = illegal | misal;

    wstrb_o = '0;
    wdata_o = '0;
    if (is_st && !is_ld) begin
      unique case (f3)
        F3_B: begin
          wstrb_o = 4'b0001 << addr_lo_i;
          wdata_o = {4{st_data_i[7:0]}};
        end
        F3_H: begin
          wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
          wdata_o = {2{st_data_i[15:0]}};
        end
        F3_W: begin
          wstrb_o = 4'b1111;
          wdata_o = st_data_i;
        end
        default: begin
          wstrb_o = '0;
          wdata_o = '0;
        end
      endcase
    end

    rshift  = rdata_i >> {ld_off_i, 3'b000};
    ld_byte = rshift[7:0];
    ld_half = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    unique case (ld_f3_i)
      F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data_o = {24'h000000, ld_byte};
      F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data_o = {16'h0000, ld_half};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM-stage load/store unit. Takes EX results, performs bus loads/stores
// over a req/ack handshake, and returns the registered write-back value.
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid, mem_op, rd_en, rd, exresult, result_address : EX-stage inputs
//   stall             : unit busy, upstream holds
//   memdata           : registered write-back value (forwarded to EX)
//   wb_valid/wb_rd_en/wb_rd : write-back pulse, enable, register
//   misalign, bus_err : one-cycle fault pulses
//   dmem_*            : data-memory bus
module mem_access
  import cpu_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [4:0]  mem_op,
  input  logic        rd_en,
  input  logic [4:0]  rd,
  input  logic [31:0] exresult,
  input  logic [31:0] result_address,
  output logic        stall,
  output logic [31:0] memdata,
  output logic        wb_valid,
  output logic        wb_rd_en,
  output logic [4:0]  wb_rd,
  output logic        misalign,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  mem_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  ld_f3_q, ld_f3_d;
  logic [1:0]  ld_off_q, ld_off_d;
  logic [4:0]  tx_rd_q, tx_rd_d;
  logic        tx_rd_en_q, tx_rd_en_d;
  logic [31:0] memdata_q, memdata_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_rd_en_q, wb_rd_en_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;

  logic        al_is_mem;
  logic        al_fault;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata;
  logic [31:0] al_ld_data;

  mem_align u_align (
    .mem_op_i  (mem_op),
    .addr_lo_i (result_address[1:0]),
    .st_data_i (exresult),
    .ld_f3_i   (ld_f3_q),
    .ld_off_i  (ld_off_q),
    .rdata_i   (dmem_rdata),
    .is_mem_o  (al_is_mem),
    .fault_o   (al_fault),
    .wstrb_o   (al_wstrb),
    .wdata_o   (al_wdata),
    .ld_data_o (al_ld_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wstrb_d    = wstrb_q;
    wdata_d    = wdata_q;
    ld_f3_d    = ld_f3_q;
    ld_off_d   = ld_off_q;
    tx_rd_d    = tx_rd_q;
    tx_rd_en_d = tx_rd_en_q;
    memdata_d  = memdata_q;
    wb_rd_d    = wb_rd_q;
    wb_valid_d = 1'b0;
    wb_rd_en_d = 1'b0;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (!al_is_mem) begin
            wb_valid_d = 1'b1;
            memdata_d  = exresult;
            wb_rd_d    = rd;
            wb_rd_en_d = rd_en;
          end else if (al_fault) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd;
            misalign_d = 1'b1;
          end else begin
            state_d    = S_WAIT;
            cnt_d      = '0;
            addr_d     = {result_address[31:2], 2'b00};
            we_d       = mem_op[MEMOP_STORE];
            wstrb_d    = al_wstrb;
            wdata_d    = al_wdata;
            ld_f3_d    = mem_op[2:0];
            ld_off_d   = result_address[1:0];
            tx_rd_d    = rd;
            tx_rd_en_d = rd_en;
          end
        end
      end
      S_WAIT: begin
        if (dmem_ack) begin
          state_d    = S_IDLE;
          cnt_d      = '0;
          wb_valid_d = 1'b1;
          wb_rd_d    = tx_rd_q;
          if (!we_q) begin
            memdata_d  = al_ld_data;
            wb_rd_en_d = tx_rd_en_q;
          end
          addr_d  = '0;
          we_d    = 1'b0;
          wstrb_d = '0;
          wdata_d = '0;
        // Compare against MAX_WAIT-1 so the abort happens on the edge where
        // the count would reach MAX_WAIT: exactly MAX_WAIT request cycles.
        end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
          state_d    = S_IDLE;
          cnt_d      = '0;
          wb_valid_d = 1'b1;
          wb_rd_d    = tx_rd_q;
          bus_err_d  = 1'b1;
          addr_d     = '0;
          we_d       = 1'b0;
          wstrb_d    = '0;
          wdata_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wstrb_q    <= '0;
      wdata_q    <= '0;
      ld_f3_q    <= '0;
      ld_off_q   <= '0;
      tx_rd_q    <= '0;
      tx_rd_en_q <= 1'b0;
      memdata_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_en_q <= 1'b0;
      wb_rd_q    <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wstrb_q    <= wstrb_d;
      wdata_q    <= wdata_d;
      ld_f3_q    <= ld_f3_d;
      ld_off_q   <= ld_off_d;
      tx_rd_q    <= tx_rd_d;
      tx_rd_en_q <= tx_rd_en_d;
      memdata_q  <= memdata_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_en_q <= wb_rd_en_d;
      wb_rd_q    <= wb_rd_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Request and stall follow the state register, so an async reset drops
  // them immediately.
  assign stall      = (state_q == S_WAIT);
  assign dmem_req   = (state_q == S_WAIT);
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wstrb = wstrb_q;
  assign dmem_wdata = wdata_q;
  assign memdata    = memdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_rd_en   = wb_rd_en_q;
  assign wb_rd      = wb_rd_q;
  assign misalign   = misalign_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus pushes expected write-back and
// bus-request records; a negedge monitor pops and compares them.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  mem_op = '0;
  logic        rd_en = 1'b0;
  logic [4:0]  rd = '0;
  logic [31:0] exresult = '0;
  logic [31:0] result_address = '0;
  logic        stall;
  logic [31:0] memdata;
  logic        wb_valid;
  logic        wb_rd_en;
  logic [4:0]  wb_rd;
  logic        misalign;
  logic        bus_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;

  mem_access #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mem_op(mem_op),
    .rd_en(rd_en), .rd(rd), .exresult(exresult), .result_address(result_address),
    .stall(stall), .memdata(memdata), .wb_valid(wb_valid), .wb_rd_en(wb_rd_en),
    .wb_rd(wb_rd), .misalign(misalign), .bus_err(bus_err), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] md;
    logic        chk_md;
    logic        rd_en;
    logic [4:0]  rd;
    logic        mis;
    logic        berr;
  } wb_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } bus_exp_t;

  wb_exp_t  wb_q[$];
  bus_exp_t bus_q[$];

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor
  wb_exp_t  we_cur;
  bus_exp_t be_cur;
  logic     have_bus = 1'b0;
  logic     req_prev = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wb_valid) begin
        if (wb_q.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
        else begin
          we_cur = wb_q.pop_front();
          chk("wb_rd_en", {31'd0, wb_rd_en}, {31'd0, we_cur.rd_en});
          if (we_cur.rd_en) chk("wb_rd", {27'd0, wb_rd}, {27'd0, we_cur.rd});
          if (we_cur.chk_md) chk("memdata", memdata, we_cur.md);
          chk("misalign", {31'd0, misalign}, {31'd0, we_cur.mis});
          chk("bus_err", {31'd0, bus_err}, {31'd0, we_cur.berr});
        end
      end else if (misalign || bus_err) begin
        chk("stray_pulse", {30'd0, misalign, bus_err}, 32'd0);
      end
      if (dmem_req) begin
        if (!req_prev) begin
          if (bus_q.size() == 0) begin
            chk("req_unexpected", 32'd1, 32'd0);
            have_bus = 1'b0;
          end else begin
            be_cur   = bus_q.pop_front();
            have_bus = 1'b1;
            chk("dmem_addr", dmem_addr, be_cur.addr);
            chk("dmem_we", {31'd0, dmem_we}, {31'd0, be_cur.we});
            chk("dmem_wstrb", {28'd0, dmem_wstrb}, {28'd0, be_cur.wstrb});
            chk("dmem_wdata", dmem_wdata, be_cur.wdata);
          end
        end else if (have_bus) begin
          if (dmem_addr !== be_cur.addr || dmem_we !== be_cur.we ||
              dmem_wstrb !== be_cur.wstrb || dmem_wdata !== be_cur.wdata)
            chk("bus_stable", 32'd0, 32'd1);
        end
      end
    end
    req_prev = dmem_req;
  end

  task automatic push_wb(input logic [31:0] md, input logic chk_md, input logic ren,
                         input logic [4:0] r, input logic mis, input logic berr);
    wb_exp_t e;
    e.md = md; e.chk_md = chk_md; e.rd_en = ren; e.rd = r; e.mis = mis; e.berr = berr;
    wb_q.push_back(e);
  endtask

  task automatic push_bus(input logic [31:0] a, input logic w, input logic [3:0] s,
                          input logic [31:0] d);
    bus_exp_t e;
    e.addr = a; e.we = w; e.wstrb = s; e.wdata = d;
    bus_q.push_back(e);
  endtask

  task automatic accept(input logic [4:0] op, input logic [4:0] r, input logic ren,
                        input logic [31:0] data, input logic [31:0] addr);
    @(posedge clk); #1;
    in_valid = 1'b1; mem_op = op; rd = r; rd_en = ren;
    exresult = data; result_address = addr;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // ack_at: WAIT cycle (1-based) on which ack is given; 0 = never.
  task automatic run(input string name, input logic [4:0] op, input logic [4:0] r,
                     input logic ren, input logic [31:0] data, input logic [31:0] addr,
                     input int ack_at, input logic [31:0] rdata, input int exp_stalls);
    int  stalls = 0;
    bit  done = 0;
    accept(op, r, ren, data, addr);
    for (int g = 0; g < 20 && !done; g++) begin
      @(negedge clk);
      if (!stall) done = 1;
      else begin
        stalls++;
        if (stalls == ack_at) begin
          dmem_ack = 1'b1; dmem_rdata = rdata;
        end
        @(posedge clk); #1;
        dmem_ack = 1'b0; dmem_rdata = 32'h5A5A5A5A;
      end
    end
    chk({name, "_stalls"}, stalls, exp_stalls);
  endtask

  initial begin
    #2;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_memdata", memdata, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // ALU passthrough
    push_wb(32'h12345678, 1, 1, 5'd5, 0, 0);
    run("alu", 5'b00000, 5'd5, 1, 32'h12345678, 32'h0, 0, 0, 0);
    // SB at byte 3
    push_bus(32'h1000, 1, 4'b1000, 32'hABABABAB);
    push_wb(0, 0, 0, 0, 0, 0);
    run("sb", 5'b10000, 5'd0, 0, 32'h000000AB, 32'h1003, 1, 0, 1);
    // LB byte 2 of 0x80FF7F01 = 0xFF, ack delay 3
    push_bus(32'h2000, 0, 4'b0000, 32'h0);
    push_wb(32'hFFFFFFFF, 1, 1, 5'd7, 0, 0);
    run("lb", 5'b01000, 5'd7, 1, 32'h0, 32'h2002, 3, 32'h80FF7F01, 3);
    // LBU byte 3 = 0x80
    push_bus(32'h2000, 0, 4'b0000, 32'h0);
    push_wb(32'h00000080, 1, 1, 5'd8, 0, 0);
    run("lbu", 5'b01100, 5'd8, 1, 32'h0, 32'h2003, 1, 32'h80FF7F01, 1);
    // LH upper half 0x80FF, sign-extended
    push_bus(32'h2000, 0, 4'b0000, 32'h0);
    push_wb(32'hFFFF80FF, 1, 1, 5'd9, 0, 0);
    run("lh", 5'b01001, 5'd9, 1, 32'h0, 32'h2002, 1, 32'h80FF7F01, 1);
    // LHU lower half 0x7F01
    push_bus(32'h2000, 0, 4'b0000, 32'h0);
    push_wb(32'h00007F01, 1, 1, 5'd10, 0, 0);
    run("lhu", 5'b01101, 5'd10, 1, 32'h0, 32'h2000, 1, 32'h80FF7F01, 1);
    // LW, ack delay 2
    push_bus(32'h2004, 0, 4'b0000, 32'h0);
    push_wb(32'hDEADBEEF, 1, 1, 5'd11, 0, 0);
    run("lw", 5'b01010, 5'd11, 1, 32'h0, 32'h2004, 2, 32'hDEADBEEF, 2);
    // SH upper half
    push_bus(32'h1000, 1, 4'b1100, 32'hBEEFBEEF);
    push_wb(0, 0, 0, 0, 0, 0);
    run("sh", 5'b10001, 5'd0, 0, 32'h0000BEEF, 32'h1002, 1, 0, 1);
    // SW
    push_bus(32'h1008, 1, 4'b1111, 32'hCAFEF00D);
    push_wb(0, 0, 0, 0, 0, 0);
    run("sw", 5'b10010, 5'd0, 0, 32'hCAFEF00D, 32'h1008, 1, 0, 1);
    // Misaligned / illegal accesses: no request, no stall
    push_wb(0, 0, 0, 0, 1, 0);
    run("mis_lw", 5'b01010, 5'd12, 1, 32'h0, 32'h2002, 0, 0, 0);
    push_wb(0, 0, 0, 0, 1, 0);
    run("mis_sh", 5'b10001, 5'd0, 0, 32'h0, 32'h1001, 0, 0, 0);
    push_wb(0, 0, 0, 0, 1, 0);
    run("ill_both", 5'b11010, 5'd13, 1, 32'h0, 32'h2000, 0, 0, 0);
    push_wb(0, 0, 0, 0, 1, 0);
    run("ill_st3", 5'b10011, 5'd0, 0, 32'h0, 32'h2000, 0, 0, 0);
    push_wb(0, 0, 0, 0, 1, 0);
    run("ill_ld6", 5'b01110, 5'd14, 1, 32'h0, 32'h2000, 0, 0, 0);

    // Ack in IDLE must be ignored
    @(posedge clk); #1; dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1; dmem_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_stall", {31'd0, stall}, 32'd0);

    // Timeout: MAX_WAIT=4, no ack -> 4 request cycles then bus_err
    push_bus(32'h4000, 0, 4'b0000, 32'h0);
    push_wb(0, 0, 0, 0, 0, 1);
    run("timeout", 5'b01010, 5'd15, 1, 32'h0, 32'h4000, 0, 0, 4);
    // Ack on the 4th WAIT cycle wins over the timeout
    push_bus(32'h4000, 0, 4'b0000, 32'h0);
    push_wb(32'h11223344, 1, 1, 5'd16, 0, 0);
    run("ack_at_max", 5'b01010, 5'd16, 1, 32'h0, 32'h4000, 4, 32'h11223344, 4);

    // Reset mid-transaction
    push_bus(32'h2000, 0, 4'b0000, 32'h0);
    accept(5'b01010, 5'd17, 1, 32'h0, 32'h2000);
    @(negedge clk);
    chk("pre_rst_req", {31'd0, dmem_req}, 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, dmem_req}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    chk("mid_rst_memdata", memdata, 32'd0);
    chk("mid_rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    push_bus(32'h3000, 1, 4'b1111, 32'h55AA55AA);
    push_wb(0, 0, 0, 0, 0, 0);
    run("sw_after_rst", 5'b10010, 5'd0, 0, 32'h55AA55AA, 32'h3000, 1, 0, 1);

    repeat (3) @(negedge clk);
    chk("wb_q_empty", wb_q.size(), 32'd0);
    chk("bus_q_empty", bus_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
